// File: rtl/ga_dispatch_rob.sv
// ga_dispatch_rob: hands core GA requests to idle units round-robin in the
// same cycle and returns unit results to the core strictly in request order
// through a small reorder buffer. A per-unit watchdog retires hung units with
// an error result so the core can never deadlock on a missing response.
module ga_dispatch_rob #(
    parameter int unsigned NumUnits      = 2,
    parameter int unsigned Depth         = 4,
    parameter int unsigned ReqWidth      = 96,
    parameter int unsigned RespWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          core_req_valid_i,
    output logic                          core_req_ready_o,
    input  logic [ReqWidth-1:0]           core_req_i,
    output logic                          core_resp_valid_o,
    input  logic                          core_resp_ready_i,
    output logic [RespWidth-1:0]          core_resp_o,
    output logic                          core_resp_err_o,
    output logic [NumUnits-1:0]           unit_req_valid_o,
    input  logic [NumUnits-1:0]           unit_req_ready_i,
    output logic [ReqWidth-1:0]           unit_req_o,
    input  logic [NumUnits-1:0]           unit_resp_valid_i,
    input  logic [NumUnits*RespWidth-1:0] unit_resp_i,
    output logic [$clog2(Depth+1)-1:0]    outstanding_o,
    output logic                          timeout_o
);

    localparam int unsigned PtrW  = $clog2(Depth);
    localparam int unsigned CntW  = $clog2(Depth + 1);
    localparam int unsigned UnitW = (NumUnits > 1) ? $clog2(NumUnits) : 1;
    localparam int unsigned WdogW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);
    // Last watchdog value before expiry; unused when the watchdog is disabled.
    localparam logic [WdogW-1:0] WdogLast = (TimeoutCycles > 0) ? WdogW'(TimeoutCycles - 1) : '0;

    // ROB bookkeeping
    logic [PtrW-1:0]      head_q;
    logic [PtrW-1:0]      tail_q;
    logic [CntW-1:0]      count_q;
    logic                 rob_done_q [Depth];
    logic                 rob_err_q  [Depth];
    logic [RespWidth-1:0] rob_res_q  [Depth];

    // Per-unit bookkeeping
    logic [UnitW-1:0]     rr_q;
    logic [NumUnits-1:0]  busy_q;
    logic [NumUnits-1:0]  drop_q;
    logic [PtrW-1:0]      slot_q [NumUnits];
    logic [WdogW-1:0]     wdog_q [NumUnits];
    logic                 timeout_q;

    logic [NumUnits-1:0]  eligible;
    logic [NumUnits-1:0]  comp;
    logic [NumUnits-1:0]  expire;
    logic [UnitW-1:0]     sel;
    logic                 avail;
    logic                 rob_full;
    logic                 alloc;
    logic                 retire;

    // Unit index (base + off) wrapped into 0..NumUnits-1; off < NumUnits.
    function automatic logic [UnitW-1:0] unit_wrap(input logic [UnitW-1:0] base,
                                                   input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NumUnits) s = s - NumUnits;
        return UnitW'(s);
    endfunction

    assign eligible = ~(busy_q | drop_q);
    assign rob_full = (count_q == DepthCnt);

    // Round-robin pick: first eligible unit at or after rr_q.
    always_comb begin
        sel   = rr_q;
        avail = 1'b0;
        for (int k = 0; k < NumUnits; k++) begin
            if (!avail && eligible[unit_wrap(rr_q, k)]) begin
                sel   = unit_wrap(rr_q, k);
                avail = 1'b1;
            end
        end
    end

    // One-hot issue valid; never depends on the unit's ready.
    always_comb begin
        unit_req_valid_o = '0;
        if (core_req_valid_i && avail && !rob_full) unit_req_valid_o[sel] = 1'b1;
    end

    assign core_req_ready_o  = avail && !rob_full && unit_req_ready_i[sel];
    assign alloc             = core_req_valid_i && core_req_ready_o;
    assign unit_req_o        = core_req_i;

    assign core_resp_valid_o = (count_q != '0) && rob_done_q[head_q];
    assign core_resp_o       = rob_res_q[head_q];
    assign core_resp_err_o   = rob_err_q[head_q];
    assign retire            = core_resp_valid_o && core_resp_ready_i;

    assign outstanding_o     = count_q;
    assign timeout_o         = timeout_q;

    // Per-unit completion and expiry; a response in the expiry cycle wins.
    always_comb begin
        comp   = '0;
        expire = '0;
        for (int u = 0; u < NumUnits; u++) begin
            comp[u]   = busy_q[u] && unit_resp_valid_i[u];
            expire[u] = (TimeoutCycles != 0) && busy_q[u] && !unit_resp_valid_i[u] &&
                        (wdog_q[u] == WdogLast);
        end
    end

    // ROB pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= '0;
        end else begin
            if (alloc) begin
                tail_q <= tail_q + PtrW'(1);
                rr_q   <= unit_wrap(sel, 1);
            end
            if (retire) head_q <= head_q + PtrW'(1);
            if (alloc && !retire)      count_q <= count_q + CntW'(1);
            else if (!alloc && retire) count_q <= count_q - CntW'(1);
        end
    end

    // Per-unit busy/drop/slot/watchdog and the sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q    <= '0;
            drop_q    <= '0;
            timeout_q <= 1'b0;
            for (int u = 0; u < NumUnits; u++) begin
                slot_q[u] <= '0;
                wdog_q[u] <= '0;
            end
        end else begin
            if (|expire) timeout_q <= 1'b1;
            for (int u = 0; u < NumUnits; u++) begin
                if (alloc && (sel == UnitW'(u))) begin
                    busy_q[u] <= 1'b1;
                    slot_q[u] <= tail_q;
                    wdog_q[u] <= '0;
                end else if (busy_q[u]) begin
                    if (comp[u]) begin
                        busy_q[u] <= 1'b0;
                    end else if (expire[u]) begin
                        busy_q[u] <= 1'b0;
                        drop_q[u] <= 1'b1;
                    end else begin
                        wdog_q[u] <= wdog_q[u] + WdogW'(1);
                    end
                end else if (drop_q[u] && unit_resp_valid_i[u]) begin
                    // The late response of a timed-out operation is swallowed here.
                    drop_q[u] <= 1'b0;
                end
            end
        end
    end

    // ROB entry contents: cleared on allocation, filled on completion or expiry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < Depth; e++) begin
                rob_done_q[e] <= 1'b0;
                rob_err_q[e]  <= 1'b0;
                rob_res_q[e]  <= '0;
            end
        end else begin
            if (alloc) rob_done_q[tail_q] <= 1'b0;
            for (int u = 0; u < NumUnits; u++) begin
                if (comp[u]) begin
                    rob_done_q[slot_q[u]] <= 1'b1;
                    rob_err_q[slot_q[u]]  <= 1'b0;
                    rob_res_q[slot_q[u]]  <= unit_resp_i[u*RespWidth +: RespWidth];
                end else if (expire[u]) begin
                    rob_done_q[slot_q[u]] <= 1'b1;
                    rob_err_q[slot_q[u]]  <= 1'b1;
                    rob_res_q[slot_q[u]]  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ga_dispatch_rob.sv
// tb_ga_dispatch_rob: randomized traffic against a sequence-number based
// reference model of the dispatch/reorder behaviour.
module tb_ga_dispatch_rob;

    localparam int N      = 4;
    localparam int D      = 4;
    localparam int REQ_W  = 96;
    localparam int RESP_W = 32;
    localparam int TO     = 16;
    localparam int MS     = 64;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      core_req_valid;
    logic                      core_req_ready;
    logic [REQ_W-1:0]          core_req;
    logic                      core_resp_valid;
    logic                      core_resp_ready;
    logic [RESP_W-1:0]         core_resp;
    logic                      core_resp_err;
    logic [N-1:0]              unit_req_valid;
    logic [N-1:0]              unit_req_ready;
    logic [REQ_W-1:0]          unit_req;
    logic [N-1:0]              unit_resp_valid;
    logic [N*RESP_W-1:0]       unit_resp;
    logic [$clog2(D+1)-1:0]    outstanding;
    logic                      timeout;

    ga_dispatch_rob #(
        .NumUnits(N), .Depth(D), .ReqWidth(REQ_W), .RespWidth(RESP_W), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .core_req_valid_i(core_req_valid), .core_req_ready_o(core_req_ready), .core_req_i(core_req),
        .core_resp_valid_o(core_resp_valid), .core_resp_ready_i(core_resp_ready),
        .core_resp_o(core_resp), .core_resp_err_o(core_resp_err),
        .unit_req_valid_o(unit_req_valid), .unit_req_ready_i(unit_req_ready), .unit_req_o(unit_req),
        .unit_resp_valid_i(unit_resp_valid), .unit_resp_i(unit_resp),
        .outstanding_o(outstanding), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    // Reference model: requests are numbered by sequence; ROB = [head_seq, tail_seq).
    int          head_seq, tail_seq, rr;
    bit          m_timeout;
    bit          m_busy [N];
    bit          m_drop [N];
    int          m_id   [N];
    int          m_issue[N];
    bit          r_done [MS];
    bit          r_err  [MS];
    logic [31:0] r_res  [MS];

    // Behavioural units: one scheduled response each.
    bit          pend     [N];
    int          pend_at  [N];
    logic [31:0] pend_data[N];

    bit          e_avail, e_ready, e_rvalid;
    int          e_sel;
    logic [N-1:0] e_uvalid;

    int p_valid, p_rready, p_uready, p_spur, lat_mode, lat_fix;
    bit tog_rready;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(99));
        case (lat_mode)
            1:       return lat_fix;
            2:       return TO + 3;
            3:       return TO;
            4: begin
                if (r < 10)      return TO;
                else if (r < 20) return TO + 1 + int'($urandom_range(3));
                else             return 1 + int'($urandom_range(5));
            end
            default: return 1 + int'($urandom_range(5));
        endcase
    endfunction

    task automatic model_comb();
        int u;
        e_avail = 1'b0;
        e_sel   = 0;
        for (int k = 0; k < N; k++) begin
            u = (rr + k) % N;
            if (!e_avail && !m_busy[u] && !m_drop[u]) begin
                e_avail = 1'b1;
                e_sel   = u;
            end
        end
        e_ready  = e_avail && ((tail_seq - head_seq) < D) && unit_req_ready[e_sel];
        e_uvalid = '0;
        if (core_req_valid && e_avail && ((tail_seq - head_seq) < D)) e_uvalid[e_sel] = 1'b1;
        e_rvalid = (tail_seq != head_seq) && r_done[head_seq % MS];
    endtask

    task automatic model_update();
        int s;
        edge_n++;
        for (int u = 0; u < N; u++) begin
            if (unit_resp_valid[u]) begin
                if (m_busy[u]) begin
                    s = m_id[u] % MS;
                    r_done[s] = 1'b1;
                    r_err[s]  = 1'b0;
                    r_res[s]  = unit_resp[u*RESP_W +: RESP_W];
                    m_busy[u] = 1'b0;
                end else if (m_drop[u]) begin
                    m_drop[u] = 1'b0;
                end
            end else if (m_busy[u] && (edge_n - m_issue[u] == TO)) begin
                s = m_id[u] % MS;
                r_done[s] = 1'b1;
                r_err[s]  = 1'b1;
                r_res[s]  = '0;
                m_busy[u] = 1'b0;
                m_drop[u] = 1'b1;
                m_timeout = 1'b1;
            end
            if (pend[u] && pend_at[u] == edge_n) pend[u] = 1'b0;
        end
        if (core_req_valid && e_ready) begin
            s = tail_seq % MS;
            r_done[s] = 1'b0;
            r_err[s]  = 1'b0;
            r_res[s]  = '0;
            m_busy[e_sel]    = 1'b1;
            m_id[e_sel]      = tail_seq;
            m_issue[e_sel]   = edge_n;
            tail_seq++;
            rr = (e_sel + 1) % N;
            pend[e_sel]      = 1'b1;
            pend_at[e_sel]   = edge_n + pick_lat();
            pend_data[e_sel] = $urandom | 32'h1;
        end
        if (e_rvalid && core_resp_ready) head_seq++;
    endtask

    // Called at a falling edge: drive, check, take the rising edge, return at the next falling edge.
    task automatic step();
        core_req_valid = (int'($urandom_range(99)) < p_valid);
        core_req       = {$urandom, $urandom, $urandom};
        if (tog_rready) core_resp_ready = ~core_resp_ready;
        else            core_resp_ready = (int'($urandom_range(99)) < p_rready);
        for (int u = 0; u < N; u++) begin
            unit_req_ready[u]               = (int'($urandom_range(99)) < p_uready);
            unit_resp_valid[u]              = 1'b0;
            unit_resp[u*RESP_W +: RESP_W]   = $urandom;
            if (pend[u] && pend_at[u] == edge_n + 1) begin
                unit_resp_valid[u]            = 1'b1;
                unit_resp[u*RESP_W +: RESP_W] = pend_data[u];
            end else if (!pend[u] && !m_busy[u] && !m_drop[u] &&
                         int'($urandom_range(99)) < p_spur) begin
                unit_resp_valid[u] = 1'b1;
            end
        end
        #1;
        model_comb();
        chk("core_req_ready", 128'(core_req_ready), 128'(e_ready));
        chk("unit_req_valid", 128'(unit_req_valid), 128'(e_uvalid));
        chk("unit_req_payload", 128'(unit_req), 128'(core_req));
        chk("core_resp_valid", 128'(core_resp_valid), 128'(e_rvalid));
        if (e_rvalid) begin
            chk("core_resp_data", 128'(core_resp), 128'(r_res[head_seq % MS]));
            chk("core_resp_err", 128'(core_resp_err), 128'(r_err[head_seq % MS]));
        end
        chk("outstanding", 128'(outstanding), 128'(tail_seq - head_seq));
        chk("timeout", 128'(timeout), 128'(m_timeout));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic knobs(input int v, input int rr_p, input int ur, input int sp, input int lm, input int lf);
        p_valid = v; p_rready = rr_p; p_uready = ur; p_spur = sp; lat_mode = lm; lat_fix = lf;
        tog_rready = 1'b0;
    endtask

    // Called at a falling edge; asserts reset mid-cycle and releases on a later falling edge.
    task automatic do_reset(input int cycles);
        #2;
        rst_n           = 1'b0;
        core_req_valid  = 1'b0;
        core_req        = '0;
        core_resp_ready = 1'b0;
        unit_req_ready  = '0;
        unit_resp_valid = '0;
        unit_resp       = '0;
        #1;
        chk("rst_core_resp_valid", 128'(core_resp_valid), 128'(0));
        chk("rst_core_resp", 128'(core_resp), 128'(0));
        chk("rst_core_resp_err", 128'(core_resp_err), 128'(0));
        chk("rst_outstanding", 128'(outstanding), 128'(0));
        chk("rst_timeout", 128'(timeout), 128'(0));
        chk("rst_unit_req_valid", 128'(unit_req_valid), 128'(0));
        chk("rst_core_req_ready", 128'(core_req_ready), 128'(0));
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            edge_n++;
        end
        @(negedge clk);
        rst_n     = 1'b1;
        head_seq  = 0;
        tail_seq  = 0;
        rr        = 0;
        m_timeout = 1'b0;
        for (int u = 0; u < N; u++) begin
            m_busy[u] = 1'b0;
            m_drop[u] = 1'b0;
            if (pend[u] && pend_at[u] <= edge_n) pend[u] = 1'b0;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        core_req_valid  = 1'b0;
        core_req        = '0;
        core_resp_ready = 1'b0;
        unit_req_ready  = '0;
        unit_resp_valid = '0;
        unit_resp       = '0;
        head_seq = 0; tail_seq = 0; rr = 0; m_timeout = 1'b0;
        for (int u = 0; u < N; u++) begin
            m_busy[u] = 1'b0; m_drop[u] = 1'b0; m_id[u] = 0; m_issue[u] = 0;
            pend[u] = 1'b0; pend_at[u] = 0; pend_data[u] = '0;
        end
        for (int i = 0; i < MS; i++) begin
            r_done[i] = 1'b0; r_err[i] = 1'b0; r_res[i] = '0;
        end
        knobs(0, 100, 100, 0, 0, 1);

        @(negedge clk);
        do_reset(3);

        // Every unit answers exactly in its expiry cycle: responses win, no timeout.
        knobs(40, 100, 100, 0, 3, 0);
        run(60);
        chk("race_no_timeout", 128'(timeout), 128'(0));
        knobs(0, 100, 100, 0, 0, 1);
        run(40);
        chk("drain_empty", 128'(outstanding), 128'(0));

        // Units answer too late: error results, sticky flag, late data swallowed.
        knobs(100, 100, 100, 0, 2, 0);
        run(2);
        knobs(0, 100, 100, 0, 2, 0);
        run(30);
        chk("timeout_sticky", 128'(timeout), 128'(1));
        run(20);

        // ROB fills to Depth with the core refusing results, then drains.
        knobs(100, 0, 100, 0, 1, 10);
        run(25);
        chk("full_count", 128'(outstanding), 128'(D));
        chk("full_stall", 128'(core_req_ready), 128'(0));
        knobs(100, 100, 100, 0, 1, 10);
        run(12);

        // Toggling backpressure with mixed latencies, races, timeouts and spurious strobes.
        knobs(70, 0, 80, 10, 4, 0);
        tog_rready = 1'b1;
        run(400);
        knobs(60, 50, 80, 10, 4, 0);
        run(400);
        knobs(0, 100, 100, 0, 0, 1);
        run(40);

        // Reset with three requests in flight; their responses arrive afterwards.
        knobs(100, 0, 100, 0, 1, 12);
        run(3);
        chk("pre_reset_outstanding", 128'(outstanding), 128'(3));
        do_reset(2);
        knobs(0, 100, 100, 0, 0, 1);
        run(20);
        knobs(60, 70, 90, 5, 0, 1);
        run(60);
        knobs(0, 100, 100, 0, 0, 1);
        run(40);
        chk("final_empty", 128'(outstanding), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ga_dispatch_rob.md
# ga_dispatch_rob

Parametrised dispatch and reorder stage between the core-side GA request port and a pool of `NumUnits` GA coprocessor units. It accepts GA requests from the core and issues each one, in the same cycle, to an idle unit chosen round-robin. It collects out-of-order unit responses into a `Depth`-entry reorder buffer (ROB) and returns results to the core strictly in request order. A per-unit watchdog retires hung operations with an error, so the core never deadlocks.

## Interface
Parameters:
- `NumUnits`, 2: number of GA units, 1..8.
- `Depth`, 4: ROB entries; power of two, ≥2.
- `ReqWidth`, 96: opaque request payload width (packed GA request).
- `RespWidth`, 32: result width.
- `TimeoutCycles`, 1024: watchdog limit in cycles; 0 disables the watchdog.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `core_req_valid_i` in 1: core request valid.
- `core_req_ready_o` out 1: request accepted when high together with valid.
- `core_req_i` in ReqWidth: request payload.
- `core_resp_valid_o` out 1: in-order result valid.
- `core_resp_ready_i` in 1: core accepts the result.
- `core_resp_o` out RespWidth: result data.
- `core_resp_err_o` out 1: result produced by a timeout, not by a unit.
- `unit_req_valid_o` out NumUnits: one-hot issue valid.
- `unit_req_ready_i` in NumUnits: unit can accept an issue.
- `unit_req_o` out ReqWidth: issue payload, shared by all units, equal to `core_req_i`.
- `unit_resp_valid_i` in NumUnits: unit result strobe, single cycle, no backpressure.
- `unit_resp_i` in NumUnits*RespWidth: unit u's result in bits [u*RespWidth +: RespWidth].
- `outstanding_o` out $clog2(Depth+1): occupied ROB entries.
- `timeout_o` out 1: sticky; set on any watchdog expiry, cleared only by reset.

## Operation
- **ROB state:**
  - Circular buffer with `tail` (alloc), `head` (retire) and `count`.
  - Each entry holds `done`, `err` and `result`.
- **Per-unit state:**
  - `busy`: one outstanding operation per unit.
  - `drop`: discard the next response from this unit.
  - `slot`: ROB index of the unit's operation.
  - `wdog` counter.
- **Unit selection:**
  - `sel` is the first unit at or after round-robin pointer `rr` (wrapping) with `busy=0` and `drop=0`.
  - `avail` = such a unit exists.
- **Issue:**
  - `unit_req_valid_o[sel]` = `core_req_valid_i` && `avail` && `count<Depth`. All other bits of `unit_req_valid_o` are 0.
  - `core_req_ready_o` = `avail` && `count<Depth` && `unit_req_ready_i[sel]`. This is combinational from the unit's ready; valid never depends on ready.
  - On the core handshake:
    - Entry `tail` is cleared (`done=0`).
    - `unit.slot` = `tail`, `busy=1`, `wdog=0`.
    - `tail` advances, wrapping at Depth.
    - `rr` = `sel+1` mod NumUnits.
- **Completion:**
  - `unit_resp_valid_i[u]` with `busy[u]=1`: writes `result` to entry `slot[u]`, sets `done=1`, `err=0`, and clears `busy[u]`.
  - Several units completing in the same cycle are all captured.
- **Dropped or spurious responses:**
  - Response with `drop[u]=1`: data is discarded, `drop` is cleared, and the unit becomes selectable.
  - Response with `busy=0` and `drop=0`: ignored.
- **Watchdog** (`TimeoutCycles>0`):
  - `wdog` increments each cycle while the unit is busy.
  - If no response has arrived by the cycle in which `wdog == TimeoutCycles-1`, then at that edge:
    - Entry `slot[u]` gets `done=1`, `err=1`, `result=0`.
    - `busy[u]=0`, `drop[u]=1`, `timeout_o=1`.
  - A response arriving in the expiry cycle takes priority: it completes normally and no timeout is recorded.
- **Retire:**
  - `core_resp_valid_o` = `count>0` && `entry[head].done`.
  - `core_resp_o` and `core_resp_err_o` come from `entry[head]`.
  - On handshake, `head` advances.
  - Valid and data are held stable until ready.
- **Count:**
  - Alloc and retire in the same cycle leave `count` unchanged.
  - `outstanding_o` = `count`.
- **Full or no unit:**
  - ROB full, or no eligible unit: `core_req_ready_o=0` and no `unit_req_valid_o` bit is set.
  - A retire frees the slot for the following cycle only. There is no same-cycle bypass.
- **Reset:**
  - Asserting `rst_ni` mid-operation discards all in-flight state.
  - All outputs go to 0, including `timeout_o`.
  - Pointers, `count`, `rr`, `busy`, `drop` and `wdog` go to 0.

## Timing
- Issue is zero-cycle: the core handshake and the unit handshake occur in the same cycle.
- Completion is registered on the clock edge. `core_resp_valid_o` rises the cycle after `unit_resp_valid_i` if that entry is at `head`.
- Minimum core-to-core latency is the unit latency + 1 cycle.
- Sustained throughput is 1 request/cycle while units and ROB space are available.
- Reset values:
  - `core_req_ready_o` follows its combinational equation after reset. It is 1 once a unit is ready, because all units are idle and `count=0`.
  - `core_resp_valid_o=0`, `outstanding_o=0`, `timeout_o=0`.

## Test plan
- **Round-robin and reorder** (NumUnits=2, Depth=4):
  - Stimulus: issue A→unit0, B→unit1. unit1 responds 0x22 at t+2; unit0 responds 0x11 at t+5.
  - Required: core receives 0x11 then 0x22, in that order. `outstanding_o` goes 2→2→1→0.
- **Full ROB:**
  - Stimulus: Depth=4, units always ready with 10-cycle latency, core holds resp_ready=0.
  - Required: exactly 4 requests are accepted (NumUnits=4). A 5th is stalled with `core_req_ready_o=0` until one result retires, then accepted the following cycle.
- **Timeout:**
  - Stimulus: TimeoutCycles=8; unit0 never responds.
  - Required: 8 cycles after issue, the core sees `err=1`, result 0, `timeout_o=1`. Unit0 is skipped by selection until its late response 0xDEAD arrives; that response is discarded and unit0 is reused afterwards.
- **Timeout race:**
  - Stimulus: response 0x5 arrives in the expiry cycle.
  - Required: core gets 0x5 with `err=0`, and `timeout_o` stays 0.
- **Backpressure and simultaneous events:**
  - Stimulus: core toggles resp_ready every cycle while new requests are issued and two units complete in the same cycle.
  - Required: results stay in order, no loss, data held stable during stalls, and `count` remains correct on alloc+retire cycles.
- **Reset mid-flight:**
  - Stimulus: assert `rst_ni` with 3 outstanding requests.
  - Required: all outputs are 0 during reset. After release, stale unit responses are ignored and a new request completes normally.
